// File: rtl/mem_bus_arbiter_pkg.sv
// Shared definitions for the memory bus arbiter: FSM state encodings,
// owner IDs and default widths.
// Build option: ARB_ROUND_ROBIN_EN alternates I/D priority on ties.
package mem_bus_arbiter_pkg;

    localparam int WORD_SIZE_DEF = 16;
    localparam int READ_SIZE_DEF = 4 * WORD_SIZE_DEF;

    // Arbiter FSM states (3-bit encoding)
    typedef enum logic [2:0] {
        ARB_IDLE    = 3'd0,
        ARB_OWN_I   = 3'd1,
        ARB_OWN_D   = 3'd2,
        ARB_OWN_DMA = 3'd3,
        ARB_DRAIN   = 3'd4
    } arb_state_e;

    // Owner IDs returned by the priority picker
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_I    = 2'd1,
        OWN_D    = 2'd2,
        OWN_DMA  = 2'd3
    } owner_e;

    // Encoding of the 1-bit last-cache-owner register
    localparam logic LAST_I = 1'b0;
    localparam logic LAST_D = 1'b1;

endpackage

// File: rtl/mem_bus_arbiter_arb_pick.sv
// Combinational owner select for the memory bus arbiter.
// DMA always wins. Between the caches, D beats I by default; with
// ARB_ROUND_ROBIN_EN defined, a tie goes to the cache that did not own last.
module arb_pick
    import mem_bus_arbiter_pkg::*;
(
    input  logic   br,
    input  logic   d_req,
    input  logic   i_req,
    input  logic   last_owner,
    output owner_e owner
);

`ifndef ARB_ROUND_ROBIN_EN
    // Fixed priority never looks at history
    logic unused_last_owner;
    assign unused_last_owner = last_owner;
`endif

    // Priority select: DMA, then the cache tie-break, then single requesters
    always_comb begin
        owner = OWN_NONE;
        if (br) begin
            owner = OWN_DMA;
        end else if (d_req && i_req) begin
`ifdef ARB_ROUND_ROBIN_EN
            owner = (last_owner == LAST_D) ? OWN_I : OWN_D;
`else
            owner = OWN_D;
`endif
        end else if (d_req) begin
            owner = OWN_D;
        end else if (i_req) begin
            owner = OWN_I;
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Memory bus arbiter: shares one memory port between I-cache, D-cache and DMA.
// A registered FSM picks one owner per transaction, the memory port mirrors
// that owner combinationally, and completion pulses are routed back to it only.
// Build option: ARB_ROUND_ROBIN_EN (alternating I/D tie-break; fixed D > I otherwise).
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int WORD_SIZE = WORD_SIZE_DEF,
    parameter int READ_SIZE = 4 * WORD_SIZE
) (
    input  logic                 clk,
    input  logic                 reset_n,
    // I-cache side
    input  logic                 i_readM,
    input  logic [WORD_SIZE-1:0] i_addressM,
    output logic                 i_bus_granted,
    output logic                 i_input_readyM,
    output logic [READ_SIZE-1:0] i_rdata,
    // D-cache side
    input  logic                 d_readM,
    input  logic                 d_writeM,
    input  logic [WORD_SIZE-1:0] d_addressM,
    input  logic [READ_SIZE-1:0] d_wdata,
    output logic                 d_bus_granted,
    output logic                 d_input_readyM,
    output logic                 d_doneM,
    output logic [READ_SIZE-1:0] d_rdata,
    // DMA handshake
    input  logic                 br,
    output logic                 bg,
    // Memory side
    output logic                 readM,
    output logic                 writeM,
    output logic [WORD_SIZE-1:0] addressM,
    output logic [READ_SIZE-1:0] mem_wdata,
    input  logic                 input_readyM,
    input  logic                 doneM,
    input  logic [READ_SIZE-1:0] mem_rdata,
    // Grant statistics
    output logic [15:0]          num_grants_i,
    output logic [15:0]          num_grants_d,
    output logic [15:0]          num_grants_dma
);

    arb_state_e state_q, state_d;
    logic       bg_q, i_bg_q, d_bg_q;
    logic [15:0] cnt_i_q, cnt_i_d;
    logic [15:0] cnt_d_q, cnt_d_d;
    logic [15:0] cnt_dma_q, cnt_dma_d;
    logic       last_owner;
    owner_e     pick;
    logic       d_req;
    logic       d_end;

    assign d_req = d_readM | d_writeM;
    // A D-cache transaction ends on the pulse that matches its request type
    assign d_end = d_readM ? input_readyM : doneM;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_owner_q, last_owner_d;
    assign last_owner = last_owner_q;
`else
    assign last_owner = LAST_I;
`endif

    arb_pick u_pick (
        .br         (br),
        .d_req      (d_req),
        .i_req      (i_readM),
        .last_owner (last_owner),
        .owner      (pick)
    );

    // Next-state, grant counters and tie-break history
    always_comb begin
        state_d   = state_q;
        cnt_i_d   = cnt_i_q;
        cnt_d_d   = cnt_d_q;
        cnt_dma_d = cnt_dma_q;
`ifdef ARB_ROUND_ROBIN_EN
        last_owner_d = last_owner_q;
`endif
        case (state_q)
            ARB_IDLE: begin
                case (pick)
                    OWN_DMA: begin
                        state_d   = ARB_OWN_DMA;
                        cnt_dma_d = cnt_dma_q + 16'd1;
                    end
                    OWN_D: begin
                        state_d = ARB_OWN_D;
                        cnt_d_d = cnt_d_q + 16'd1;
`ifdef ARB_ROUND_ROBIN_EN
                        last_owner_d = LAST_D;
`endif
                    end
                    OWN_I: begin
                        state_d = ARB_OWN_I;
                        cnt_i_d = cnt_i_q + 16'd1;
`ifdef ARB_ROUND_ROBIN_EN
                        last_owner_d = LAST_I;
`endif
                    end
                    default: ;
                endcase
            end
            // Completion or an abandoned request both release the bus via DRAIN
            ARB_OWN_I:   if (!i_readM || input_readyM) state_d = ARB_DRAIN;
            ARB_OWN_D:   if (!d_req || d_end)          state_d = ARB_DRAIN;
            ARB_OWN_DMA: if (!br)                      state_d = ARB_IDLE;
            ARB_DRAIN:   state_d = ARB_IDLE;
            default:     state_d = ARB_IDLE;
        endcase
    end

    // FSM state, registered grant outputs and counters
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= ARB_IDLE;
            bg_q      <= 1'b0;
            i_bg_q    <= 1'b0;
            d_bg_q    <= 1'b0;
            cnt_i_q   <= 16'd0;
            cnt_d_q   <= 16'd0;
            cnt_dma_q <= 16'd0;
`ifdef ARB_ROUND_ROBIN_EN
            last_owner_q <= LAST_I;
`endif
        end else begin
            state_q   <= state_d;
            bg_q      <= (state_d == ARB_OWN_DMA);
            i_bg_q    <= (state_d == ARB_OWN_DMA) || (state_d == ARB_OWN_D);
            d_bg_q    <= (state_d == ARB_OWN_DMA) || (state_d == ARB_OWN_I);
            cnt_i_q   <= cnt_i_d;
            cnt_d_q   <= cnt_d_d;
            cnt_dma_q <= cnt_dma_d;
`ifdef ARB_ROUND_ROBIN_EN
            last_owner_q <= last_owner_d;
`endif
        end
    end

    // Memory port mirrors the current cache owner; completions go to it alone
    always_comb begin
        readM          = 1'b0;
        writeM         = 1'b0;
        addressM       = '0;
        mem_wdata      = '0;
        i_input_readyM = 1'b0;
        d_input_readyM = 1'b0;
        d_doneM        = 1'b0;
        case (state_q)
            ARB_OWN_I: begin
                readM          = i_readM;
                addressM       = i_addressM;
                i_input_readyM = i_readM & input_readyM;
            end
            ARB_OWN_D: begin
                readM          = d_readM;
                writeM         = d_writeM;
                addressM       = d_addressM;
                mem_wdata      = d_wdata;
                d_input_readyM = d_readM & input_readyM;
                d_doneM        = ~d_readM & d_writeM & doneM;
            end
            default: ;
        endcase
    end

    assign bg             = bg_q;
    assign i_bus_granted  = i_bg_q;
    assign d_bus_granted  = d_bg_q;
    assign i_rdata        = mem_rdata;
    assign d_rdata        = mem_rdata;
    assign num_grants_i   = cnt_i_q;
    assign num_grants_d   = cnt_d_q;
    assign num_grants_dma = cnt_dma_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Testbench for mem_bus_arbiter: vector table plus short hand-written
// sequences for reset and tie-break corners, checked through a scoreboard queue.
module tb_mem_bus_arbiter;

    localparam logic [15:0] A_I = 16'h0040;
    localparam logic [15:0] A_D = 16'h0100;
    localparam logic [63:0] W_D = 64'h1111_2222_3333_4444;
    localparam logic [1:0]  MX_N = 2'd0;
    localparam logic [1:0]  MX_I = 2'd1;
    localparam logic [1:0]  MX_D = 2'd2;

    logic        clk;
    logic        reset_n;
    logic        i_readM, d_readM, d_writeM, br, input_readyM, doneM;
    logic [15:0] i_addressM, d_addressM, addressM;
    logic [63:0] d_wdata, mem_wdata, mem_rdata, i_rdata, d_rdata;
    logic        i_bus_granted, i_input_readyM;
    logic        d_bus_granted, d_input_readyM, d_doneM;
    logic        bg, readM, writeM;
    logic [15:0] num_grants_i, num_grants_d, num_grants_dma;

    mem_bus_arbiter dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .i_readM        (i_readM),
        .i_addressM     (i_addressM),
        .i_bus_granted  (i_bus_granted),
        .i_input_readyM (i_input_readyM),
        .i_rdata        (i_rdata),
        .d_readM        (d_readM),
        .d_writeM       (d_writeM),
        .d_addressM     (d_addressM),
        .d_wdata        (d_wdata),
        .d_bus_granted  (d_bus_granted),
        .d_input_readyM (d_input_readyM),
        .d_doneM        (d_doneM),
        .d_rdata        (d_rdata),
        .br             (br),
        .bg             (bg),
        .readM          (readM),
        .writeM         (writeM),
        .addressM       (addressM),
        .mem_wdata      (mem_wdata),
        .input_readyM   (input_readyM),
        .doneM          (doneM),
        .mem_rdata      (mem_rdata),
        .num_grants_i   (num_grants_i),
        .num_grants_d   (num_grants_d),
        .num_grants_dma (num_grants_dma)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // in  = {reset_n, i_readM, d_readM, d_writeM, br, input_readyM, doneM}
    // ctl = {bg, i_bus_granted, d_bus_granted, i_input_readyM, d_input_readyM, d_doneM}
    // rw  = {readM, writeM}; mux selects which requester's address/data must appear
    typedef struct packed {
        logic [6:0]  in;
        logic [5:0]  ctl;
        logic [1:0]  rw;
        logic [1:0]  mux;
        logic [15:0] ni;
        logic [15:0] nd;
        logic [15:0] ndma;
    } vec_t;

    typedef struct packed {
        vec_t        v;
        logic [63:0] rdata;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    vec_t tbl[38];

    task automatic chk(input string nm, input string f, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s %s: got %h, expected %h", nm, f, act, exp);
        end
    endtask

    // Drive one cycle of stimulus after the edge, check outputs on the falling edge
    task automatic step(input string nm, input vec_t v);
        exp_t        e;
        logic [15:0] ea;
        logic [63:0] ew;
        @(posedge clk);
        #1;
        {reset_n, i_readM, d_readM, d_writeM, br, input_readyM, doneM} = v.in;
        mem_rdata = {$urandom, $urandom};
        exp_q.push_back('{v: v, rdata: mem_rdata});
        @(negedge clk);
        e  = exp_q.pop_front();
        ea = (e.v.mux == MX_I) ? A_I : (e.v.mux == MX_D) ? A_D : 16'h0000;
        ew = (e.v.mux == MX_D) ? W_D : 64'h0;
        chk(nm, "ctl", 64'({bg, i_bus_granted, d_bus_granted, i_input_readyM, d_input_readyM, d_doneM}), 64'(e.v.ctl));
        chk(nm, "rw", 64'({readM, writeM}), 64'(e.v.rw));
        chk(nm, "addressM", 64'(addressM), 64'(ea));
        chk(nm, "mem_wdata", mem_wdata, ew);
        chk(nm, "num_grants_i", 64'(num_grants_i), 64'(e.v.ni));
        chk(nm, "num_grants_d", 64'(num_grants_d), 64'(e.v.nd));
        chk(nm, "num_grants_dma", 64'(num_grants_dma), 64'(e.v.ndma));
        chk(nm, "i_rdata", i_rdata, e.rdata);
        chk(nm, "d_rdata", d_rdata, e.rdata);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected summary");
        $fatal(1);
    end

    initial begin
        vec_t h;
        // reset held with a request present, then single I read
        tbl[0]  = '{7'b0100000, 6'b000000, 2'b00, MX_N, 16'd0, 16'd0, 16'd0};
        tbl[1]  = '{7'b1100000, 6'b000000, 2'b00, MX_N, 16'd0, 16'd0, 16'd0};
        tbl[2]  = '{7'b1100000, 6'b001000, 2'b10, MX_I, 16'd1, 16'd0, 16'd0};
        tbl[3]  = '{7'b1100010, 6'b001100, 2'b10, MX_I, 16'd1, 16'd0, 16'd0};
        tbl[4]  = '{7'b1000000, 6'b000000, 2'b00, MX_N, 16'd1, 16'd0, 16'd0};
        tbl[5]  = '{7'b1000000, 6'b000000, 2'b00, MX_N, 16'd1, 16'd0, 16'd0};
        // D and I tie: D first, I granted after DRAIN and IDLE
        tbl[6]  = '{7'b1110000, 6'b000000, 2'b00, MX_N, 16'd1, 16'd0, 16'd0};
        tbl[7]  = '{7'b1110000, 6'b010000, 2'b10, MX_D, 16'd1, 16'd1, 16'd0};
        tbl[8]  = '{7'b1110010, 6'b010010, 2'b10, MX_D, 16'd1, 16'd1, 16'd0};
        tbl[9]  = '{7'b1100000, 6'b000000, 2'b00, MX_N, 16'd1, 16'd1, 16'd0};
        tbl[10] = '{7'b1100000, 6'b000000, 2'b00, MX_N, 16'd1, 16'd1, 16'd0};
        tbl[11] = '{7'b1100000, 6'b001000, 2'b10, MX_I, 16'd2, 16'd1, 16'd0};
        tbl[12] = '{7'b1100010, 6'b001100, 2'b10, MX_I, 16'd2, 16'd1, 16'd0};
        tbl[13] = '{7'b1000000, 6'b000000, 2'b00, MX_N, 16'd2, 16'd1, 16'd0};
        // br during a D write waits for doneM
        tbl[14] = '{7'b1001000, 6'b000000, 2'b00, MX_N, 16'd2, 16'd1, 16'd0};
        tbl[15] = '{7'b1001100, 6'b010000, 2'b01, MX_D, 16'd2, 16'd2, 16'd0};
        tbl[16] = '{7'b1001101, 6'b010001, 2'b01, MX_D, 16'd2, 16'd2, 16'd0};
        tbl[17] = '{7'b1000100, 6'b000000, 2'b00, MX_N, 16'd2, 16'd2, 16'd0};
        tbl[18] = '{7'b1000100, 6'b000000, 2'b00, MX_N, 16'd2, 16'd2, 16'd0};
        tbl[19] = '{7'b1000100, 6'b111000, 2'b00, MX_N, 16'd2, 16'd2, 16'd1};
        tbl[20] = '{7'b1000000, 6'b111000, 2'b00, MX_N, 16'd2, 16'd2, 16'd1};
        tbl[21] = '{7'b1000000, 6'b000000, 2'b00, MX_N, 16'd2, 16'd2, 16'd1};
        // all three request: DMA, then D, then I; simultaneous pulses filtered
        tbl[22] = '{7'b1101100, 6'b000000, 2'b00, MX_N, 16'd2, 16'd2, 16'd1};
        tbl[23] = '{7'b1101100, 6'b111000, 2'b00, MX_N, 16'd2, 16'd2, 16'd2};
        tbl[24] = '{7'b1101000, 6'b111000, 2'b00, MX_N, 16'd2, 16'd2, 16'd2};
        tbl[25] = '{7'b1101000, 6'b000000, 2'b00, MX_N, 16'd2, 16'd2, 16'd2};
        tbl[26] = '{7'b1101000, 6'b010000, 2'b01, MX_D, 16'd2, 16'd3, 16'd2};
        tbl[27] = '{7'b1101011, 6'b010001, 2'b01, MX_D, 16'd2, 16'd3, 16'd2};
        tbl[28] = '{7'b1100000, 6'b000000, 2'b00, MX_N, 16'd2, 16'd3, 16'd2};
        tbl[29] = '{7'b1100000, 6'b000000, 2'b00, MX_N, 16'd2, 16'd3, 16'd2};
        tbl[30] = '{7'b1100011, 6'b001100, 2'b10, MX_I, 16'd3, 16'd3, 16'd2};
        tbl[31] = '{7'b1000000, 6'b000000, 2'b00, MX_N, 16'd3, 16'd3, 16'd2};
        // spurious pulses in IDLE, abandoned D read, pulse in DRAIN
        tbl[32] = '{7'b1000011, 6'b000000, 2'b00, MX_N, 16'd3, 16'd3, 16'd2};
        tbl[33] = '{7'b1010000, 6'b000000, 2'b00, MX_N, 16'd3, 16'd3, 16'd2};
        tbl[34] = '{7'b1010000, 6'b010000, 2'b10, MX_D, 16'd3, 16'd4, 16'd2};
        tbl[35] = '{7'b1000000, 6'b010000, 2'b00, MX_D, 16'd3, 16'd4, 16'd2};
        tbl[36] = '{7'b1000010, 6'b000000, 2'b00, MX_N, 16'd3, 16'd4, 16'd2};
        tbl[37] = '{7'b1000000, 6'b000000, 2'b00, MX_N, 16'd3, 16'd4, 16'd2};

        reset_n      = 1'b0;
        i_readM      = 1'b0;
        d_readM      = 1'b0;
        d_writeM     = 1'b0;
        br           = 1'b0;
        input_readyM = 1'b0;
        doneM        = 1'b0;
        i_addressM   = A_I;
        d_addressM   = A_D;
        d_wdata      = W_D;
        mem_rdata    = 64'h0;
        repeat (3) @(posedge clk);

        for (int k = 0; k < 38; k++) step($sformatf("vec%0d", k), tbl[k]);

        // reset while I owns the bus
        step("rst_req",   '{7'b1100000, 6'b000000, 2'b00, MX_N, 16'd3, 16'd4, 16'd2});
        step("rst_own",   '{7'b0100000, 6'b001000, 2'b10, MX_I, 16'd4, 16'd4, 16'd2});
        step("rst_after", '{7'b1000000, 6'b000000, 2'b00, MX_N, 16'd0, 16'd0, 16'd0});

        // two consecutive I/D ties after reset
        step("tie1",       '{7'b1110000, 6'b000000, 2'b00, MX_N, 16'd0, 16'd0, 16'd0});
        step("tie1_own",   '{7'b1110010, 6'b010010, 2'b10, MX_D, 16'd0, 16'd1, 16'd0});
        step("tie1_drain", '{7'b1100000, 6'b000000, 2'b00, MX_N, 16'd0, 16'd1, 16'd0});
        step("tie2",       '{7'b1110000, 6'b000000, 2'b00, MX_N, 16'd0, 16'd1, 16'd0});
`ifdef ARB_ROUND_ROBIN_EN
        h = '{7'b1110000, 6'b001000, 2'b10, MX_I, 16'd1, 16'd1, 16'd0};
        step("tie2_own", h);
        h = '{7'b1110010, 6'b001100, 2'b10, MX_I, 16'd1, 16'd1, 16'd0};
        step("tie2_done", h);
        h = '{7'b1000000, 6'b000000, 2'b00, MX_N, 16'd1, 16'd1, 16'd0};
        step("tie2_drain", h);
`else
        h = '{7'b1110000, 6'b010000, 2'b10, MX_D, 16'd0, 16'd2, 16'd0};
        step("tie2_own", h);
        h = '{7'b1110010, 6'b010010, 2'b10, MX_D, 16'd0, 16'd2, 16'd0};
        step("tie2_done", h);
        h = '{7'b1000000, 6'b000000, 2'b00, MX_N, 16'd0, 16'd2, 16'd0};
        step("tie2_drain", h);
`endif

        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard: %0d entries left, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
